// File: rtl/s4_pkg.sv
// s4 core shared definitions: data width, access-size encodings,
// arbiter state encoding and the alignment-mask helper.
package s4_pkg;

   localparam int XLEN = 64;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_e;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      logic [2:0] m;
      m = 3'b000;
      unique case (size)
         SZ_B: m = 3'b000;
         SZ_H: m = 3'b001;
         SZ_W: m = 3'b011;
         SZ_D: m = 3'b111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Byte-lane generation for stores and data extraction for loads.
// Ports: size_i/off_i select lanes; wdata_i/rdata_i in, be_o/wdata_o/rdata_o out.
module ls_lane_align
   import s4_pkg::*;
(
   input  logic [1:0]      size_i,
   input  logic [2:0]      off_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [7:0]      be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o
);

   logic [7:0]      be_base;
   logic [XLEN-1:0] mask;
   logic [XLEN-1:0] shifted;

   always_comb begin
      be_base = 8'h01;
      mask    = 64'hFF;
      unique case (size_i)
         SZ_B: begin be_base = 8'h01; mask = 64'h0000_0000_0000_00FF; end
         SZ_H: begin be_base = 8'h03; mask = 64'h0000_0000_0000_FFFF; end
         SZ_W: begin be_base = 8'h0F; mask = 64'h0000_0000_FFFF_FFFF; end
         SZ_D: begin be_base = 8'hFF; mask = 64'hFFFF_FFFF_FFFF_FFFF; end
      endcase
   end

   assign be_o    = be_base << off_i;
   assign wdata_o = wdata_i << {off_i, 3'b000};
   assign shifted = rdata_i >> {off_i, 3'b000};
   assign rdata_o = shifted & mask;

endmodule

// File: rtl/mem_port_arb.sv
// IF/LS arbiter in front of a fixed-latency 64-bit single-port memory.
// Ports: if_* fetch port, ls_* load/store port, m_* memory port; all outputs registered.
module mem_port_arb
   import s4_pkg::*;
#(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [31:0]     if_rdata,
   output logic            if_err,
   input  logic            ls_req,
   input  logic            ls_we,
   input  logic [1:0]      ls_size,
   input  logic [XLEN-1:0] ls_addr,
   input  logic [XLEN-1:0] ls_wdata,
   output logic            ls_gnt,
   output logic            ls_rvalid,
   output logic [XLEN-1:0] ls_rdata,
   output logic            ls_err,
   output logic            m_en,
   output logic            m_we,
   output logic [XLEN-1:0] m_addr,
   output logic [7:0]      m_be,
   output logic [XLEN-1:0] m_wdata,
   input  logic [XLEN-1:0] m_rdata
);

   localparam int CW = 8;
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

   arb_state_e state_q, state_d;

   logic            sel_ls_q, sel_ls_d;
   logic            we_q, we_d;
   logic [1:0]      size_q, size_d;
   logic [2:0]      off_q, off_d;
   logic            mis_q, mis_d;
   logic [CW-1:0]   lat_q, lat_d;
   logic [CW-1:0]   starve_q, starve_d;

   logic            if_gnt_q, if_gnt_d;
   logic            if_rvalid_q, if_rvalid_d;
   logic [31:0]     if_rdata_q, if_rdata_d;
   logic            if_err_q, if_err_d;
   logic            ls_gnt_q, ls_gnt_d;
   logic            ls_rvalid_q, ls_rvalid_d;
   logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;
   logic            ls_err_q, ls_err_d;
   logic            m_en_q, m_en_d;
   logic            m_we_q, m_we_d;
   logic [XLEN-1:0] m_addr_q, m_addr_d;
   logic [7:0]      m_be_q, m_be_d;
   logic [XLEN-1:0] m_wdata_q, m_wdata_d;

   logic            idle;
   logic            if_win, ls_win;
   logic            if_mis, ls_mis;
   logic [CW-1:0]   lat_lim;
   logic [1:0]      al_size;
   logic [2:0]      al_off;
   logic [7:0]      al_be;
   logic [XLEN-1:0] al_wdata;
   logic [XLEN-1:0] al_rdata;

   assign idle   = (state_q == ARB_IDLE);
   assign if_win = if_req && (!ls_req || starve_q == SMAX);
   assign ls_win = ls_req && !if_win;
   assign if_mis = (if_addr[1:0] != 2'b00);
   assign ls_mis = ((ls_addr[2:0] & align_mask(ls_size)) != 3'b000);

   // A misaligned access never reaches memory; it waits one cycle only.
   assign lat_lim = mis_q ? CW'(1) : CW'(MEM_LAT);

   // Lane logic sees live LS inputs while arbitrating, latched payload after.
   assign al_size = idle ? ls_size : size_q;
   assign al_off  = idle ? ls_addr[2:0] : off_q;

   ls_lane_align u_align (
      .size_i  (al_size),
      .off_i   (al_off),
      .wdata_i (ls_wdata),
      .rdata_i (m_rdata),
      .be_o    (al_be),
      .wdata_o (al_wdata),
      .rdata_o (al_rdata)
   );

   always_comb begin
      state_d     = state_q;
      sel_ls_d    = sel_ls_q;
      we_d        = we_q;
      size_d      = size_q;
      off_d       = off_q;
      mis_d       = mis_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      if_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      if_rdata_d  = '0;
      if_err_d    = 1'b0;
      ls_gnt_d    = 1'b0;
      ls_rvalid_d = 1'b0;
      ls_rdata_d  = '0;
      ls_err_d    = 1'b0;
      m_en_d      = 1'b0;
      m_we_d      = 1'b0;
      m_addr_d    = '0;
      m_be_d      = '0;
      m_wdata_d   = '0;

      unique case (state_q)
         ARB_IDLE: begin
            unique case (1'b1)
               ls_win: begin
                  state_d  = ARB_ACCESS;
                  lat_d    = '0;
                  sel_ls_d = 1'b1;
                  we_d     = ls_we;
                  size_d   = ls_size;
                  off_d    = ls_addr[2:0];
                  mis_d    = ls_mis;
                  ls_gnt_d = 1'b1;
                  if (if_req && starve_q != SMAX)
                     starve_d = starve_q + CW'(1);
                  if (!ls_mis) begin
                     m_en_d    = 1'b1;
                     m_we_d    = ls_we;
                     m_addr_d  = {ls_addr[63:3], 3'b000};
                     m_be_d    = ls_we ? al_be : 8'hFF;
                     m_wdata_d = ls_we ? al_wdata : '0;
                  end
               end
               if_win: begin
                  state_d  = ARB_ACCESS;
                  lat_d    = '0;
                  sel_ls_d = 1'b0;
                  we_d     = 1'b0;
                  size_d   = SZ_W;
                  off_d    = if_addr[2:0];
                  mis_d    = if_mis;
                  if_gnt_d = 1'b1;
                  starve_d = '0;
                  if (!if_mis) begin
                     m_en_d   = 1'b1;
                     m_addr_d = {if_addr[63:3], 3'b000};
                     m_be_d   = 8'hFF;
                  end
               end
               default: ;
            endcase
         end
         ARB_ACCESS: begin
            if (lat_q == lat_lim) begin
               state_d = ARB_RESP;
               if (sel_ls_q) begin
                  ls_rvalid_d = 1'b1;
                  ls_err_d    = mis_q;
                  ls_rdata_d  = (mis_q || we_q) ? '0 : al_rdata;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_err_d    = mis_q;
                  if (!mis_q)
                     if_rdata_d = off_q[2] ? m_rdata[63:32] : m_rdata[31:0];
               end
            end else begin
               lat_d = lat_q + CW'(1);
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ARB_IDLE;
         sel_ls_q    <= 1'b0;
         we_q        <= 1'b0;
         size_q      <= SZ_B;
         off_q       <= '0;
         mis_q       <= 1'b0;
         lat_q       <= '0;
         starve_q    <= '0;
         if_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         if_err_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         ls_rvalid_q <= 1'b0;
         ls_rdata_q  <= '0;
         ls_err_q    <= 1'b0;
         m_en_q      <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_be_q      <= '0;
         m_wdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         sel_ls_q    <= sel_ls_d;
         we_q        <= we_d;
         size_q      <= size_d;
         off_q       <= off_d;
         mis_q       <= mis_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         if_gnt_q    <= if_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         ls_gnt_q    <= ls_gnt_d;
         ls_rvalid_q <= ls_rvalid_d;
         ls_rdata_q  <= ls_rdata_d;
         ls_err_q    <= ls_err_d;
         m_en_q      <= m_en_d;
         m_we_q      <= m_we_d;
         m_addr_q    <= m_addr_d;
         m_be_q      <= m_be_d;
         m_wdata_q   <= m_wdata_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign ls_gnt    = ls_gnt_q;
   assign ls_rvalid = ls_rvalid_q;
   assign ls_rdata  = ls_rdata_q;
   assign ls_err    = ls_err_q;
   assign m_en      = m_en_q;
   assign m_we      = m_we_q;
   assign m_addr    = m_addr_q;
   assign m_be      = m_be_q;
   assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a fixed-latency memory model.
// Memory drives real data only in the cycle MEM_LAT after m_en.
module tb_mem_port_arb;

   localparam int LAT = 2;
   localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

   logic        clock, reset_n;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        ls_req, ls_we;
   logic [1:0]  ls_size;
   logic [63:0] ls_addr, ls_wdata, ls_rdata;
   logic        ls_gnt, ls_rvalid, ls_err;
   logic        m_en, m_we;
   logic [63:0] m_addr, m_wdata, m_rdata;
   logic [7:0]  m_be;

   logic [63:0]    mem_word;
   logic [LAT-1:0] pipe;

   int n_chk;
   int n_fail;

   mem_port_arb #(.MEM_LAT(LAT), .STARVE_MAX(4)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_size   (ls_size),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_gnt    (ls_gnt),
      .ls_rvalid (ls_rvalid),
      .ls_rdata  (ls_rdata),
      .ls_err    (ls_err),
      .m_en      (m_en),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_be      (m_be),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial pipe = '0;
   always @(posedge clock) pipe <= {pipe[LAT-2:0], m_en};
   assign m_rdata = pipe[LAT-1] ? mem_word : JUNK;

   // Observations from one request, filled in by run()
   int          gc, rc, ens;
   logic [63:0] rd, ma, mw;
   logic [7:0]  be;
   logic        er, mwe;

   task automatic run(input bit use_ls, input logic we, input logic [1:0] sz,
                      input logic [63:0] a, input logic [63:0] wd);
      gc = -1; rc = -1; ens = 0;
      rd = '0; ma = '0; mw = '0; be = '0; er = 1'b0; mwe = 1'b0;
      @(negedge clock);
      if (use_ls) begin
         ls_req = 1'b1; ls_we = we; ls_size = sz;
         ls_addr = a; ls_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = a;
      end
      for (int k = 1; k <= 20 && rc < 0; k++) begin
         @(negedge clock);
         if (use_ls ? ls_gnt : if_gnt) begin
            gc = k; ls_req = 1'b0; if_req = 1'b0;
         end
         if (m_en) begin
            ens++; ma = m_addr; mw = m_wdata; be = m_be; mwe = m_we;
         end
         if (use_ls && ls_rvalid) begin
            rc = k; rd = ls_rdata; er = ls_err;
         end
         if (!use_ls && if_rvalid) begin
            rc = k; rd = {32'h0, if_rdata}; er = if_err;
         end
      end
      ls_req = 1'b0; if_req = 1'b0;
   endtask

   task automatic test_reset();
      logic [400:0] outs;
      outs = {if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid,
              ls_rdata, ls_err, m_en, m_we, m_addr, m_be, m_wdata};
      n_chk++;
      if (outs !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
      end
      @(negedge clock); reset_n = 1'b1; @(negedge clock);
      outs = {if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid,
              ls_rdata, ls_err, m_en, m_we, m_addr, m_be, m_wdata};
      n_chk++;
      if (outs !== '0) begin
         n_fail++; $display("FAIL idle_outputs: got %h want 0", outs);
      end
   endtask

   task automatic test_if_fetch();
      mem_word = 64'hAAAA_BBBB_CCCC_DDDD;
      run(1'b0, 1'b0, 2'd0, 64'h104, '0);
      n_chk++; if (gc !== 1) begin n_fail++; $display("FAIL if_gnt_cyc: got %0d want 1", gc); end
      n_chk++; if (ma !== 64'h100) begin n_fail++; $display("FAIL if_maddr: got %h want 100", ma); end
      n_chk++; if (be !== 8'hFF) begin n_fail++; $display("FAIL if_be: got %h want ff", be); end
      n_chk++; if (ens !== 1) begin n_fail++; $display("FAIL if_men_cnt: got %0d want 1", ens); end
      n_chk++; if (rc !== 4) begin n_fail++; $display("FAIL if_rvalid_cyc: got %0d want 4", rc); end
      n_chk++; if (rd !== 64'hAAAABBBB) begin n_fail++; $display("FAIL if_rdata_hi: got %h want aaaabbbb", rd); end
      n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL if_err: got %b want 0", er); end
      run(1'b0, 1'b0, 2'd0, 64'h100, '0);
      n_chk++; if (rd !== 64'hCCCCDDDD) begin n_fail++; $display("FAIL if_rdata_lo: got %h want ccccdddd", rd); end
   endtask

   task automatic test_store();
      mem_word = 64'h5555_5555_5555_5555;
      run(1'b1, 1'b1, 2'd2, 64'h1004, 64'h1234_5678);
      n_chk++; if (be !== 8'hF0) begin n_fail++; $display("FAIL sw_be: got %h want f0", be); end
      n_chk++; if (mw !== 64'h12345678_00000000) begin n_fail++; $display("FAIL sw_wdata: got %h want 1234567800000000", mw); end
      n_chk++; if (ma !== 64'h1000) begin n_fail++; $display("FAIL sw_maddr: got %h want 1000", ma); end
      n_chk++; if (mwe !== 1'b1) begin n_fail++; $display("FAIL sw_mwe: got %b want 1", mwe); end
      n_chk++; if (rc !== 4) begin n_fail++; $display("FAIL sw_rvalid_cyc: got %0d want 4", rc); end
      n_chk++; if (rd !== 64'h0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", rd); end
      n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", er); end
      run(1'b1, 1'b1, 2'd0, 64'h1003, 64'hAB);
      n_chk++; if (be !== 8'h08) begin n_fail++; $display("FAIL sb_be: got %h want 08", be); end
      n_chk++; if (mw !== 64'h00000000_AB000000) begin n_fail++; $display("FAIL sb_wdata: got %h want ab000000", mw); end
      run(1'b1, 1'b1, 2'd1, 64'h1006, 64'hCAFE);
      n_chk++; if (be !== 8'hC0) begin n_fail++; $display("FAIL sh_be: got %h want c0", be); end
   endtask

   task automatic test_load();
      mem_word = 64'hBEEF_0000_0000_0000;
      run(1'b1, 1'b0, 2'd1, 64'h2006, '0);
      n_chk++; if (rd !== 64'hBEEF) begin n_fail++; $display("FAIL lh_rdata: got %h want beef", rd); end
      n_chk++; if (be !== 8'hFF) begin n_fail++; $display("FAIL lh_be: got %h want ff", be); end
      n_chk++; if (mwe !== 1'b0) begin n_fail++; $display("FAIL lh_mwe: got %b want 0", mwe); end
      n_chk++; if (rc !== 4) begin n_fail++; $display("FAIL lh_rvalid_cyc: got %0d want 4", rc); end
      mem_word = 64'h1122_3344_5566_7788;
      run(1'b1, 1'b0, 2'd0, 64'h2001, '0);
      n_chk++; if (rd !== 64'h77) begin n_fail++; $display("FAIL lb_rdata: got %h want 77", rd); end
      run(1'b1, 1'b0, 2'd2, 64'h2004, '0);
      n_chk++; if (rd !== 64'h11223344) begin n_fail++; $display("FAIL lw_rdata: got %h want 11223344", rd); end
      run(1'b1, 1'b0, 2'd3, 64'h2008, '0);
      n_chk++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL ld_rdata: got %h want 1122334455667788", rd); end
      n_chk++; if (ma !== 64'h2008) begin n_fail++; $display("FAIL ld_maddr: got %h want 2008", ma); end
   endtask

   task automatic test_misaligned();
      mem_word = 64'h1111_2222_3333_4444;
      run(1'b1, 1'b0, 2'd3, 64'h3004, '0);
      n_chk++; if (gc !== 1) begin n_fail++; $display("FAIL mis_ls_gnt: got %0d want 1", gc); end
      n_chk++; if (ens !== 0) begin n_fail++; $display("FAIL mis_ls_men: got %0d want 0", ens); end
      n_chk++; if (rc !== 3) begin n_fail++; $display("FAIL mis_ls_rvalid_cyc: got %0d want 3", rc); end
      n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_ls_err: got %b want 1", er); end
      n_chk++; if (rd !== 64'h0) begin n_fail++; $display("FAIL mis_ls_rdata: got %h want 0", rd); end
      run(1'b0, 1'b0, 2'd0, 64'h102, '0);
      n_chk++; if (gc !== 1) begin n_fail++; $display("FAIL mis_if_gnt: got %0d want 1", gc); end
      n_chk++; if (ens !== 0) begin n_fail++; $display("FAIL mis_if_men: got %0d want 0", ens); end
      n_chk++; if (rc !== 3) begin n_fail++; $display("FAIL mis_if_rvalid_cyc: got %0d want 3", rc); end
      n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_if_err: got %b want 1", er); end
      n_chk++; if (rd !== 64'h0) begin n_fail++; $display("FAIL mis_if_rdata: got %h want 0", rd); end
      run(1'b1, 1'b0, 2'd1, 64'h3003, '0);
      n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_lh_err: got %b want 1", er); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] seq;
      int ng;
      seq = '0; ng = 0;
      @(negedge clock);
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd3; ls_addr = 64'h4000;
      if_req = 1'b1; if_addr = 64'h200;
      for (int k = 0; k < 60 && ng < 6; k++) begin
         @(negedge clock);
         if (ls_gnt) begin seq = {seq[4:0], 1'b1}; ng++; end
         if (if_gnt) begin seq = {seq[4:0], 1'b0}; ng++; end
      end
      ls_req = 1'b0; if_req = 1'b0;
      n_chk++;
      if (seq !== 6'b111101 || ng !== 6) begin
         n_fail++; $display("FAIL starve_seq: got %b (%0d grants) want 111101", seq, ng);
      end
      repeat (8) @(negedge clock);
   endtask

   task automatic test_reset_mid();
      logic [400:0] outs;
      int nrv;
      nrv = 0;
      mem_word = 64'h0123_4567_89AB_CDEF;
      @(negedge clock);
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd3; ls_addr = 64'h5000;
      @(negedge clock);
      ls_req = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      outs = {if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid,
              ls_rdata, ls_err, m_en, m_we, m_addr, m_be, m_wdata};
      n_chk++;
      if (outs !== '0) begin
         n_fail++; $display("FAIL midreset_outputs: got %h want 0", outs);
      end
      @(negedge clock); reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (ls_rvalid || if_rvalid) nrv++;
      end
      n_chk++;
      if (nrv !== 0) begin n_fail++; $display("FAIL midreset_rvalid: got %0d want 0", nrv); end
      run(1'b0, 1'b0, 2'd0, 64'h300, '0);
      n_chk++; if (rc !== 4) begin n_fail++; $display("FAIL postreset_rvalid_cyc: got %0d want 4", rc); end
      n_chk++; if (rd !== 64'h89ABCDEF) begin n_fail++; $display("FAIL postreset_rdata: got %h want 89abcdef", rd); end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      reset_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_size = '0;
      ls_addr = '0; ls_wdata = '0;
      mem_word = '0;
      repeat (2) @(negedge clock);
      test_reset();
      test_if_fetch();
      test_store();
      test_load();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
